// File: rtl/bus_cmd_pkg.sv
// Shared constants, field positions and state encoding for the bus command processor.
package bus_cmd_pkg;

    localparam logic [1:0] OP_WRITE = 2'b10;
    localparam logic [1:0] OP_READ  = 2'b11;

    // Command byte layout, counted down from the MSB of the command word
    localparam int OPC_W         = 2;
    localparam int OPC_TOP_OFS   = 1;
    localparam int MSEL_TOP_OFS  = 3;
    localparam int ADDR_TOP_OFS  = 4;
    localparam int ADDR_LSB      = 0;

    typedef enum logic [2:0] {
        IDLE,
        SHIFT_CMD,
        SHIFT_DATA,
        PARITY,
        GAP
    } state_e;

    function automatic logic opcode_valid(input logic [OPC_W-1:0] op);
        return (op == OP_WRITE) || (op == OP_READ);
    endfunction

endpackage

// File: rtl/btn_edge_detect.sv
// Registered rising-edge detector for a clk-synchronous button level.
module btn_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic btn_i,
    output logic pulse_o
);

    logic prev_q;
    logic pulse_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            prev_q  <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            prev_q  <= btn_i;
            pulse_q <= btn_i & ~prev_q;
        end
    end

    assign pulse_o = pulse_q;

endmodule

// File: rtl/bus_cmd_processor.sv
// Operator-driven command processor: loads cmd/data bytes, serialises them onto one of three lanes.
// Define PARITY_EN to append an even-parity bit after the last serial bit of each transaction.
//
// state      | meaning
// IDLE       | accepting loads, launches and aborts
// SHIFT_CMD  | sending command byte MSB first
// SHIFT_DATA | sending data byte MSB first (WRITE only)
// PARITY     | sending parity of all bits sent (PARITY_EN only)
// GAP        | lanes forced idle before returning to IDLE
module bus_cmd_processor
    import bus_cmd_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int GAP_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] switch1,
    input  logic              button1,
    input  logic              button2,
    input  logic              button3,
    output logic [1:0]        data_read_m1,
    output logic [1:0]        data_read_m2,
    output logic [1:0]        data_write
);

    localparam int CNT_W = $clog2(DATA_W);
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DATA_W - 1);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES - 1);
    localparam logic PTR_CMD = 1'b0;

    logic load_p, launch_p, abort_p;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] cmd_q, cmd_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [DATA_W-1:0] sw_q;
    logic              ptr_q, ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [GAP_W-1:0]  gap_q, gap_d;

    logic [OPC_W-1:0]  opcode;
    logic              is_write, is_read, msel;
    logic              lane_vld, lane_bit;

    btn_edge_detect u_edge_b1 (.clk(clk), .reset(reset), .btn_i(button1), .pulse_o(load_p));
    btn_edge_detect u_edge_b2 (.clk(clk), .reset(reset), .btn_i(button2), .pulse_o(launch_p));
    btn_edge_detect u_edge_b3 (.clk(clk), .reset(reset), .btn_i(button3), .pulse_o(abort_p));

    assign opcode   = cmd_q[DATA_W-1-OPC_TOP_OFS +: OPC_W];
    assign is_write = (opcode == OP_WRITE);
    assign is_read  = (opcode == OP_READ);
    assign msel     = cmd_q[DATA_W-MSEL_TOP_OFS];

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            cmd_q   <= '0;
            data_q  <= '0;
            sw_q    <= '0;
            ptr_q   <= PTR_CMD;
            cnt_q   <= '0;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            data_q  <= data_d;
            sw_q    <= switch1;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
        end
    end

    // sw_q holds the switch value from the same edge that saw the button1 rise
    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        data_d  = data_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        gap_d   = gap_q;
        if (abort_p) begin
            state_d = GAP;
            gap_d   = GAP_LOAD;
            if (state_q == IDLE) begin
                cmd_d  = '0;
                data_d = '0;
                ptr_d  = PTR_CMD;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (load_p) begin
                        if (ptr_q == PTR_CMD) cmd_d = sw_q;
                        else                  data_d = sw_q;
                        ptr_d = ~ptr_q;
                    end else if (launch_p) begin
                        if (opcode_valid(opcode)) begin
                            state_d = SHIFT_CMD;
                            cnt_d   = CNT_LOAD;
                        end else begin
                            ptr_d = PTR_CMD;
                        end
                    end
                end
                SHIFT_CMD, SHIFT_DATA: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - 1'b1;
                    end else if (state_q == SHIFT_CMD && is_write) begin
                        state_d = SHIFT_DATA;
                        cnt_d   = CNT_LOAD;
                    end else begin
`ifdef PARITY_EN
                        state_d = PARITY;
`else
                        state_d = GAP;
                        gap_d   = GAP_LOAD;
`endif
                    end
                end
                PARITY: begin
                    state_d = GAP;
                    gap_d   = GAP_LOAD;
                end
                GAP: begin
                    if (gap_q == '0) begin
                        state_d = IDLE;
                        ptr_d   = PTR_CMD;
                    end else begin
                        gap_d = gap_q - 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        lane_vld     = 1'b0;
        lane_bit     = 1'b0;
        data_write   = 2'b00;
        data_read_m1 = 2'b00;
        data_read_m2 = 2'b00;
        case (state_q)
            SHIFT_CMD: begin
                lane_vld = 1'b1;
                lane_bit = cmd_q[cnt_q];
            end
            SHIFT_DATA: begin
                lane_vld = 1'b1;
                lane_bit = data_q[cnt_q];
            end
`ifdef PARITY_EN
            // Registers are frozen during a transaction, so parity comes straight from them
            PARITY: begin
                lane_vld = 1'b1;
                lane_bit = (^cmd_q) ^ (is_write & (^data_q));
            end
`endif
            default: ;
        endcase
        if (lane_vld) begin
            if (is_write)           data_write   = {1'b1, lane_bit};
            else if (is_read && !msel) data_read_m1 = {1'b1, lane_bit};
            else if (is_read)       data_read_m2 = {1'b1, lane_bit};
        end
    end

endmodule

// File: tb/tb_bus_cmd_processor.sv
// Randomised self-checking bench; predicts lane traffic per cycle from a transaction-level model.
module tb_bus_cmd_processor;

    localparam int DATA_W     = 8;
    localparam int GAP_CYCLES = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic [DATA_W-1:0] switch1;
    logic              button1, button2, button3;
    logic [1:0]        data_read_m1, data_read_m2, data_write;

    always #5 clk = ~clk;

    bus_cmd_processor #(.DATA_W(DATA_W), .GAP_CYCLES(GAP_CYCLES)) dut (
        .clk(clk), .reset(reset), .switch1(switch1),
        .button1(button1), .button2(button2), .button3(button3),
        .data_read_m1(data_read_m1), .data_read_m2(data_read_m2), .data_write(data_write)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Model: register contents, load pointer, and the expected {m1,m2,wr} lanes for upcoming samples
    logic [7:0] m_cmd = '0;
    logic [7:0] m_data = '0;
    bit         m_ptr_data = 1'b0;
    logic [5:0] exp_q[$];
    bit         p1 = 0, p2 = 0, p3 = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic void model_launch();
        logic [1:0] op;
        bit         bits[$];
        bit         par;
        int         shift;
        op  = m_cmd[7:6];
        par = 1'b0;
        m_ptr_data = 1'b0;
        if (op != 2'b10 && op != 2'b11) return;
        for (int i = 7; i >= 0; i--) bits.push_back(m_cmd[i]);
        if (op == 2'b10) for (int i = 7; i >= 0; i--) bits.push_back(m_data[i]);
`ifdef PARITY_EN
        foreach (bits[i]) par ^= bits[i];
        bits.push_back(par);
`endif
        shift = (op == 2'b10) ? 0 : (m_cmd[5] ? 2 : 4);
        exp_q.push_back(6'd0);
        foreach (bits[i]) exp_q.push_back(6'({1'b1, bits[i]}) << shift);
        repeat (GAP_CYCLES) exp_q.push_back(6'd0);
    endfunction

    // One clock: check the current sample, let the model react to what is driven now, drive it.
    task automatic cycle(input bit b1, input bit b2, input bit b3, input logic [7:0] sw, input bit rst_n);
        logic [5:0] exp;
        logic [5:0] first;
        bit         busy, e1, e2, e3;
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 6'd0;
        check_eq("lanes", 32'({data_read_m1, data_read_m2, data_write}), 32'(exp));
        busy = (exp_q.size() > 0);
        e1 = b1 & ~p1;
        e2 = b2 & ~p2;
        e3 = b3 & ~p3;
        if (!rst_n) begin
            exp_q.delete();
            m_cmd = '0;
            m_data = '0;
            m_ptr_data = 1'b0;
            e1 = 0; e2 = 0; e3 = 0;
        end else if (e3) begin
            first = busy ? exp_q[0] : 6'd0;
            if (!busy) begin
                m_cmd = '0;
                m_data = '0;
                m_ptr_data = 1'b0;
            end
            exp_q.delete();
            exp_q.push_back(first);
            repeat (GAP_CYCLES) exp_q.push_back(6'd0);
        end else if (!busy) begin
            if (e1) begin
                if (m_ptr_data) m_data = sw;
                else            m_cmd = sw;
                m_ptr_data = ~m_ptr_data;
            end else if (e2) begin
                model_launch();
            end
        end
        p1 = rst_n ? b1 : 1'b0;
        p2 = rst_n ? b2 : 1'b0;
        p3 = rst_n ? b3 : 1'b0;
        button1 = b1;
        button2 = b2;
        button3 = b3;
        switch1 = sw;
        reset   = rst_n;
        @(negedge clk);
    endtask

    task automatic press(input bit b1, input bit b2, input bit b3, input logic [7:0] sw);
        cycle(b1, b2, b3, sw, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, sw, 1'b1);
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(1'b0, 1'b0, 1'b0, switch1, 1'b1);
    endtask

    initial begin
        reset = 1'b0;
        button1 = 1'b0;
        button2 = 1'b0;
        button3 = 1'b0;
        switch1 = '0;
        @(negedge clk);
        @(negedge clk);
        cycle(0, 0, 0, 8'h00, 1'b0);

        // Launch straight after reset: cmd_reg is 0, an invalid opcode
        press(0, 1, 0, 8'h00);
        idle(12);

        // WRITE AA/AA
        press(1, 0, 0, 8'hAA);
        press(1, 0, 0, 8'hAA);
        press(0, 1, 0, 8'hAA);
        idle(20);

        // READ on m2, then m1
        press(1, 0, 0, 8'hE2);
        press(0, 1, 0, 8'hE2);
        idle(12);
        press(1, 0, 0, 8'hC2);
        press(0, 1, 0, 8'hC2);
        idle(12);

        // Invalid opcode resets the pointer, next load lands in cmd_reg
        press(1, 0, 0, 8'h62);
        press(0, 1, 0, 8'h62);
        press(1, 0, 0, 8'hC2);
        press(0, 1, 0, 8'hC2);
        idle(12);

        // Ignored loads/launches during shifting, abort mid-write, then replay
        press(1, 0, 0, 8'hAA);
        press(1, 0, 0, 8'h55);
        press(0, 1, 0, 8'h00);
        press(1, 0, 0, 8'hFF);
        cycle(0, 1, 0, 8'hFF, 1'b1);
        cycle(0, 0, 1, 8'hFF, 1'b1);
        idle(8);
        press(0, 1, 0, 8'h00);
        idle(22);

        // Load beats a simultaneous launch; abort beats a simultaneous load
        press(1, 1, 0, 8'hC2);
        idle(4);
        press(0, 1, 0, 8'h00);
        idle(12);
        press(1, 0, 1, 8'hE2);
        idle(3);
        press(0, 1, 0, 8'h00);
        idle(6);

        // Reset in the middle of a write
        press(1, 0, 0, 8'h9C);
        press(1, 0, 0, 8'h3B);
        press(0, 1, 0, 8'h00);
        idle(5);
        cycle(0, 0, 0, 8'h00, 1'b0);
        cycle(0, 0, 0, 8'h00, 1'b0);
        idle(4);

        for (int k = 0; k < 400; k++) begin
            int         r;
            logic [7:0] sw;
            r  = $urandom_range(0, 99);
            sw = 8'($urandom);
            if ($urandom_range(0, 3) != 0) sw[7] = 1'b1;
            if (r < 38)      press(1, 0, 0, sw);
            else if (r < 62) press(0, 1, 0, sw);
            else if (r < 67) press(0, 0, 1, sw);
            else if (r < 75) press(1'($urandom), 1'($urandom), 1'($urandom), sw);
            else if (r < 97) idle($urandom_range(1, 14));
            else begin
                cycle(0, 0, 0, sw, 1'b0);
                cycle(0, 0, 0, sw, 1'b0);
            end
        end
        idle(30);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
